// File: rtl/l2_cache_sa.sv
// l2_cache_sa: parametrised set-associative L2 line cache between an L1 and 128-bit line memory.
// Latency: hit -> proc_ready one cycle after the request is seen in IDLE; a miss adds memory cycles.
// Backpressure: L1 holds proc_read/proc_write until proc_ready; memory requests held until mem_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   proc_read/proc_write            L1 line read / line write request (both high acts as a write)
//   proc_addr[29:0]                 L1 word address; line address is [29:2]
//   proc_wdata/proc_rdata[127:0]    line from / to L1; proc_rdata valid while proc_ready
//   proc_ready                      one-cycle completion pulse
//   mem_read/mem_write              memory line fetch / write-back request
//   mem_addr[27:0]                  memory line address
//   mem_wdata/mem_rdata[127:0]      write-back line / fetched line
//   mem_ready                       memory completion, one cycle
//
// Build option: define L2_WRITE_EN for dirty tracking, write-back and write-allocate.
// Without it the cache is read-only towards memory: mem_write and mem_wdata are tied 0
// and a write only updates a line that already hits.

module l2_cache_sa #(
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [127:0] proc_wdata,
  output logic [127:0] proc_rdata,
  output logic         proc_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 28 - IDX;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic [27:0]   r_line;
  logic          r_wr;
  logic [127:0]  r_wdata;
  logic [WW-1:0] r_victim;

  // Line state
  logic [WAYS-1:0] r_valid [SETS];
`ifdef L2_WRITE_EN
  logic [WAYS-1:0] r_dirty [SETS];
`endif
  // pLRU: bit0 is the 2-way victim, or the tree root for 4 ways (0 = left pair);
  // bit1 picks inside ways 0/1, bit2 inside ways 2/3.
  logic [2:0]      r_lru   [SETS];
  logic [TAGW-1:0] r_tag   [WAYS][SETS];
  logic [127:0]    r_data  [WAYS][SETS];

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [2:0]      w_lru_cur;
  logic            w_hit;
  logic [WW-1:0]   w_hit_way;
  logic            w_inv_found;
  logic [WW-1:0]   w_inv_way;
  logic [1:0]      w_plru_way;
  logic [WW-1:0]   w_victim;
  logic            w_fill_mem;
  logic            w_wr_hit;
  logic            w_touch;
  logic [WW-1:0]   w_touch_way;
`ifdef L2_WRITE_EN
  logic            w_vic_dirty;
  logic            w_wr_alloc;
  logic            w_evict;
`endif
  logic            w_unused_addr_lsb;

  assign w_idx             = r_line[IDX-1:0];
  assign w_tag             = r_line[27:IDX];
  assign w_lru_cur         = r_lru[w_idx];
  assign w_unused_addr_lsb = ^proc_addr[1:0];

  // Marks way w most recently used by pointing every tree node on its path away from it.
  function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] n;
    n = s;
    if (WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end else if (WAYS == 2) begin
      n[0] = ~w[0];
    end
    return n;
  endfunction

  // Tag compare across the ways of the latched set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // Lowest-index invalid way: scan downwards so the lowest match is written last
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(w);
      end
    end
  end

  always_comb begin
    w_plru_way = 2'd0;
    if (WAYS == 4) begin
      w_plru_way = w_lru_cur[0] ? {1'b1, w_lru_cur[2]} : {1'b0, w_lru_cur[1]};
    end else if (WAYS == 2) begin
      w_plru_way = {1'b0, w_lru_cur[0]};
    end
  end

  assign w_victim = w_inv_found ? w_inv_way : WW'(w_plru_way);

  assign w_fill_mem = (r_state == S_ALLOCATE) && mem_ready;
  assign w_wr_hit   = (r_state == S_COMPARE) && r_wr && w_hit;

`ifdef L2_WRITE_EN
  assign w_vic_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
  // Write miss with a clean (or freshly evicted) victim installs the L1 line with no fetch
  assign w_wr_alloc  = (r_state == S_COMPARE) && r_wr && !w_hit && !w_vic_dirty;
  assign w_evict     = (r_state == S_WRITEBACK) && mem_ready;
  assign w_touch     = (r_state == S_COMPARE) && (w_hit || w_wr_alloc);
`else
  assign w_touch     = (r_state == S_COMPARE) && w_hit;
`endif
  assign w_touch_way = w_hit ? w_hit_way : w_victim;

  // Next state and state-decoded outputs; memory side depends only on registers
  always_comb begin
    w_state_nxt = r_state;
    proc_ready  = 1'b0;
    mem_read    = 1'b0;
    mem_addr    = '0;
`ifdef L2_WRITE_EN
    mem_write   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (proc_read || proc_write) w_state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          proc_ready  = 1'b1;
          w_state_nxt = S_IDLE;
`ifdef L2_WRITE_EN
        end else if (w_vic_dirty) begin
          w_state_nxt = S_WRITEBACK;
`endif
        end else if (r_wr) begin
          // Write miss: installed this cycle (write build) or dropped (read-only build)
          proc_ready  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ALLOCATE;
        end
      end
`ifdef L2_WRITE_EN
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[r_victim][w_idx], w_idx};
        // A write returns to COMPARE, where the now-invalid victim takes the line
        if (mem_ready) w_state_nxt = r_wr ? S_COMPARE : S_ALLOCATE;
      end
`endif
      S_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = r_line;
        if (mem_ready) w_state_nxt = S_COMPARE;
      end
      default: ;
    endcase
  end

  always_comb begin
    proc_rdata = '0;
    if (proc_ready) proc_rdata = r_wr ? r_wdata : r_data[w_hit_way][w_idx];
  end

`ifdef L2_WRITE_EN
  assign mem_wdata = (r_state == S_WRITEBACK) ? r_data[r_victim][w_idx] : '0;
`else
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
`endif

  // Control state, valid/dirty/LRU bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_line   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_victim <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_lru[s]   <= '0;
`ifdef L2_WRITE_EN
        r_dirty[s] <= '0;
`endif
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && (proc_read || proc_write)) begin
        r_line  <= proc_addr[29:2];
        r_wr    <= proc_write;
        r_wdata <= proc_wdata;
      end
      if (r_state == S_COMPARE) r_victim <= w_victim;
      if (w_fill_mem) begin
        r_valid[w_idx][r_victim] <= 1'b1;
`ifdef L2_WRITE_EN
        r_dirty[w_idx][r_victim] <= 1'b0;
`endif
      end
`ifdef L2_WRITE_EN
      if (w_evict) begin
        r_valid[w_idx][r_victim] <= 1'b0;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
      if (w_wr_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
      if (w_wr_alloc) begin
        r_valid[w_idx][w_victim] <= 1'b1;
        r_dirty[w_idx][w_victim] <= 1'b1;
      end
`endif
      if (w_touch) r_lru[w_idx] <= plru_touch(w_lru_cur, 2'(w_touch_way));
    end
  end

  // Tag and data storage: contents are qualified by valid, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_fill_mem) begin
      r_data[r_victim][w_idx] <= mem_rdata;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
    if (w_wr_hit) r_data[w_hit_way][w_idx] <= r_wdata;
`ifdef L2_WRITE_EN
    if (w_wr_alloc) begin
      r_data[w_victim][w_idx] <= r_wdata;
      r_tag[w_victim][w_idx]  <= w_tag;
    end
`endif
  end

endmodule
